fpnew_opgroup_share_arbiter: RTL and testbench

Shares one FP operation-group datapath between NumReq requesters (e.g. harts or issue lanes). Input side: round-robin arbitration with per-requester outstanding-operation credits. The requester index is prepended to the downstream tag. Output side: results return through a one-entry response register that routes each result to its owner by decoding the returned tag, so out-of-order completion across formats is handled.

---
 rtl/fpnew_opgroup_share_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_fpnew_opgroup_share_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpnew_opgroup_share_arbiter.sv
// ============================================================================
// Module  : fpnew_opgroup_share_arbiter
// Brief   : Round-robin, credit-limited sharing of one FP op-group datapath
//           among NumReq requesters, with tag-routed one-entry response register.
//           Optional: FPNEW_SHARE_PERF_EN adds per-requester stall counters.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fpnew_opgroup_share_arbiter #(
    parameter int unsigned NumReq         = 4,
    parameter int unsigned OpWidth        = 128,
    parameter int unsigned ResWidth       = 38,
    parameter int unsigned TagWidth       = 4,
    parameter int unsigned MaxOutstanding = 4,
    localparam int unsigned IdWidth       = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          flush_i,
    input  logic [NumReq-1:0]             req_valid_i,
    output logic [NumReq-1:0]             req_ready_o,
    input  logic [NumReq*OpWidth-1:0]     req_op_i,
    input  logic [NumReq*TagWidth-1:0]    req_tag_i,
    output logic                          dp_valid_o,
    input  logic                          dp_ready_i,
    output logic [OpWidth-1:0]            dp_op_o,
    output logic [IdWidth+TagWidth-1:0]   dp_tag_o,
    input  logic                          dp_result_valid_i,
    output logic                          dp_result_ready_o,
    input  logic [ResWidth-1:0]           dp_result_i,
    input  logic [IdWidth+TagWidth-1:0]   dp_result_tag_i,
    output logic [NumReq-1:0]             rsp_valid_o,
    input  logic [NumReq-1:0]             rsp_ready_i,
    output logic [ResWidth-1:0]           rsp_result_o,
    output logic [TagWidth-1:0]           rsp_tag_o,
    output logic                          id_error_o,
    output logic                          busy_o
`ifdef FPNEW_SHARE_PERF_EN
    ,
    output logic [NumReq*16-1:0]          stall_cnt_o
`endif
);

    localparam logic [3:0]         CntMax  = 4'(MaxOutstanding);
    localparam logic [IdWidth:0]   NumReqW = (IdWidth+1)'(NumReq);

    logic [IdWidth-1:0]            ptr_q, ptr_d;
    logic [NumReq-1:0][3:0]        cnt_q, cnt_d;
    logic                          lock_q, lock_d;
    logic [IdWidth-1:0]            lock_id_q, lock_id_d;
    logic                          full_q, full_d;
    logic [ResWidth-1:0]           res_q, res_d;
    logic [TagWidth-1:0]           tag_q, tag_d;
    logic [IdWidth-1:0]            id_q, id_d;
    logic                          err_q, err_d;

    logic                          active;
    logic [NumReq-1:0]             eligible;
    logic [IdWidth-1:0]            grant;
    logic                          found;
    logic [IdWidth:0]              idx;
    logic                          issue;
    logic                          rsp_fire;
    logic                          res_fire;
    logic [IdWidth-1:0]            res_id;
    logic                          res_id_ok;

    assign active = !flush_i && !rst_i;

    always_comb begin
        for (int unsigned i = 0; i < NumReq; i++) begin
            eligible[i] = req_valid_i[i] && (cnt_q[i] < CntMax);
        end
    end

    // A stalled grant stays locked so a newly valid requester cannot steal it.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            idx = {1'b0, ptr_q} + (IdWidth+1)'(k);
            if (idx >= NumReqW) idx = idx - NumReqW;
            if (!found && eligible[idx[IdWidth-1:0]]) begin
                found = 1'b1;
                grant = idx[IdWidth-1:0];
            end
        end
        if (lock_q && eligible[lock_id_q]) grant = lock_id_q;
    end

    assign dp_valid_o = (|eligible) && active;
    assign issue      = dp_valid_o && dp_ready_i;
    assign dp_op_o    = req_op_i[grant*OpWidth +: OpWidth];
    assign dp_tag_o   = {grant, req_tag_i[grant*TagWidth +: TagWidth]};

    assign rsp_fire          = full_q && active && rsp_ready_i[id_q];
    assign dp_result_ready_o = active && (!full_q || rsp_fire);
    assign res_fire          = dp_result_valid_i && dp_result_ready_o;
    assign res_id            = dp_result_tag_i[IdWidth+TagWidth-1 -: IdWidth];
    assign res_id_ok         = ({1'b0, res_id} < NumReqW);

    always_comb begin
        req_ready_o = '0;
        rsp_valid_o = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            req_ready_o[i] = issue && (grant == IdWidth'(i));
            rsp_valid_o[i] = full_q && active && (id_q == IdWidth'(i));
        end
    end

    always_comb begin
        ptr_d     = ptr_q;
        lock_d    = dp_valid_o && !dp_ready_i;
        lock_id_d = grant;
        full_d    = full_q;
        res_d     = res_q;
        tag_d     = tag_q;
        id_d      = id_q;
        err_d     = res_fire && !res_id_ok;
        cnt_d     = cnt_q;
        if (issue) ptr_d = (grant == IdWidth'(NumReq - 1)) ? '0 : grant + 1'b1;
        if (res_fire && res_id_ok) begin
            full_d = 1'b1;
            res_d  = dp_result_i;
            tag_d  = dp_result_tag_i[TagWidth-1:0];
            id_d   = res_id;
        end else if (rsp_fire) begin
            full_d = 1'b0;
        end
        for (int unsigned i = 0; i < NumReq; i++) begin
            if (issue && (grant == IdWidth'(i)) &&
                !(rsp_fire && (id_q == IdWidth'(i)) && (cnt_q[i] != 4'd0))) begin
                cnt_d[i] = cnt_q[i] + 4'd1;
            end else if (!(issue && (grant == IdWidth'(i))) &&
                         rsp_fire && (id_q == IdWidth'(i)) && (cnt_q[i] != 4'd0)) begin
                cnt_d[i] = cnt_q[i] - 4'd1;
            end
        end
        if (flush_i) begin
            ptr_d  = '0;
            lock_d = 1'b0;
            full_d = 1'b0;
            err_d  = 1'b0;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q     <= '0;
            cnt_q     <= '0;
            lock_q    <= 1'b0;
            lock_id_q <= '0;
            full_q    <= 1'b0;
            res_q     <= '0;
            tag_q     <= '0;
            id_q      <= '0;
            err_q     <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
            full_q    <= full_d;
            res_q     <= res_d;
            tag_q     <= tag_d;
            id_q      <= id_d;
            err_q     <= err_d;
        end
    end

    assign rsp_result_o = res_q;
    assign rsp_tag_o    = tag_q;
    assign id_error_o   = err_q;
    assign busy_o       = (|cnt_q) || full_q;

`ifdef FPNEW_SHARE_PERF_EN
    for (genvar gi = 0; gi < NumReq; gi++) begin : g_stall
        logic [15:0] stall_q;
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                stall_q <= '0;
            end else if (flush_i) begin
                stall_q <= '0;
            end else if (req_valid_i[gi] && !req_ready_o[gi] && (stall_q != 16'hFFFF)) begin
                stall_q <= stall_q + 16'd1;
            end
        end
        assign stall_cnt_o[gi*16 +: 16] = stall_q;
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fpnew_opgroup_share_arbiter.sv
// Bench for fpnew_opgroup_share_arbiter: bench-side datapath model feeding a
// response scoreboard, plus a NumReq=5 instance for the out-of-range id path.
`default_nettype none

module tb_fpnew_opgroup_share_arbiter;

    localparam int N   = 4;
    localparam int OW  = 128;
    localparam int RW  = 38;
    localparam int TW  = 4;
    localparam int IW  = 2;
    localparam int DTW = IW + TW;

    logic clk = 1'b0;
    logic rst, flush;
    always #5 clk = ~clk;

    logic [N-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
    logic [N*OW-1:0]  req_op;
    logic [N*TW-1:0]  req_tag;
    logic             dp_valid, dp_ready, dpr_valid, dpr_ready, id_error, busy;
    logic [OW-1:0]    dp_op;
    logic [DTW-1:0]   dp_tag, dpr_tag;
    logic [RW-1:0]    dpr_res, rsp_result;
    logic [TW-1:0]    rsp_tag;

    fpnew_opgroup_share_arbiter u_dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_op_i(req_op), .req_tag_i(req_tag),
        .dp_valid_o(dp_valid), .dp_ready_i(dp_ready),
        .dp_op_o(dp_op), .dp_tag_o(dp_tag),
        .dp_result_valid_i(dpr_valid), .dp_result_ready_o(dpr_ready),
        .dp_result_i(dpr_res), .dp_result_tag_i(dpr_tag),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_result_o(rsp_result), .rsp_tag_o(rsp_tag),
        .id_error_o(id_error), .busy_o(busy)
`ifdef FPNEW_SHARE_PERF_EN
        , .stall_cnt_o()
`endif
    );

    logic [4:0]       x_req_valid, x_req_ready, x_rsp_valid, x_rsp_ready;
    logic [5*OW-1:0]  x_req_op;
    logic [5*TW-1:0]  x_req_tag;
    logic             x_dp_valid, x_dpr_valid, x_dpr_ready, x_id_error, x_busy;
    logic [OW-1:0]    x_dp_op;
    logic [6:0]       x_dp_tag, x_dpr_tag;
    logic [RW-1:0]    x_dpr_res, x_rsp_result;
    logic [TW-1:0]    x_rsp_tag;

    fpnew_opgroup_share_arbiter #(.NumReq(5)) u_dut5 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .req_valid_i(x_req_valid), .req_ready_o(x_req_ready),
        .req_op_i(x_req_op), .req_tag_i(x_req_tag),
        .dp_valid_o(x_dp_valid), .dp_ready_i(1'b1),
        .dp_op_o(x_dp_op), .dp_tag_o(x_dp_tag),
        .dp_result_valid_i(x_dpr_valid), .dp_result_ready_o(x_dpr_ready),
        .dp_result_i(x_dpr_res), .dp_result_tag_i(x_dpr_tag),
        .rsp_valid_o(x_rsp_valid), .rsp_ready_i(x_rsp_ready),
        .rsp_result_o(x_rsp_result), .rsp_tag_o(x_rsp_tag),
        .id_error_o(x_id_error), .busy_o(x_busy)
`ifdef FPNEW_SHARE_PERF_EN
        , .stall_cnt_o()
`endif
    );

    typedef struct packed {
        logic [IW-1:0] id;
        logic [TW-1:0] tag;
        logic [RW-1:0] res;
    } rsp_t;
    typedef struct packed {
        logic [DTW-1:0] tag;
        logic [RW-1:0]  res;
    } dpr_t;

    rsp_t rsp_q[$];
    dpr_t dp_pend[$];
    bit   auto_ret;
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [RW-1:0] res_of(input logic [DTW-1:0] t);
        return {32'hC0DE_0000 | (32'(t) * 32'h0101), t};
    endfunction

    function automatic logic [OW-1:0] op_of(input int i);
        return {4{32'h1111_1111 * 32'(i + 1)}};
    endfunction

    task automatic push_dp(input logic [IW-1:0] id, input logic [TW-1:0] tag);
        dpr_t d;
        d.tag = {id, tag};
        d.res = res_of({id, tag});
        dp_pend.push_back(d);
    endtask

    task automatic drive_dp();
        dpr_valid = (dp_pend.size() != 0);
        dpr_tag   = dpr_valid ? dp_pend[0].tag : '0;
        dpr_res   = dpr_valid ? dp_pend[0].res : '0;
    endtask

    // Compare the held response against the oldest expected one; retire on handshake.
    task automatic check_rsp();
        if (rsp_valid != '0) begin
            if (rsp_q.size() == 0) begin
                check("rsp_unexpected", rsp_valid, 0);
            end else begin
                check("rsp_valid", rsp_valid, 4'b0001 << rsp_q[0].id);
                check("rsp_tag", rsp_tag, rsp_q[0].tag);
                check("rsp_result", rsp_result, rsp_q[0].res);
                if ((rsp_valid & rsp_ready) != '0) void'(rsp_q.pop_front());
            end
        end
    endtask

    task automatic at_neg();
        @(negedge clk);
        check_rsp();
    endtask

    task automatic adv();
        rsp_t e;
        dpr_t d;
        if (dp_valid && dp_ready && auto_ret) begin
            d.tag = dp_tag;
            d.res = res_of(dp_tag);
            dp_pend.push_back(d);
        end
        if (dpr_valid && dpr_ready) begin
            e.id  = dpr_tag[DTW-1 -: IW];
            e.tag = dpr_tag[TW-1:0];
            e.res = dpr_res;
            rsp_q.push_back(e);
            void'(dp_pend.pop_front());
        end
        @(posedge clk);
        #1;
        drive_dp();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        flush = 1'b0;
        req_valid = '0; rsp_ready = '0; dp_ready = 1'b0;
        x_req_valid = '0; x_rsp_ready = '0; x_dpr_valid = 1'b0;
        x_dpr_tag = '0; x_dpr_res = '0; x_req_op = '0; x_req_tag = '0;
        auto_ret = 1'b0;
        rsp_q.delete();
        dp_pend.delete();
        drive_dp();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < N; i++) req_op[i*OW +: OW] = op_of(i);
        req_tag = '0;
        do_reset();

        // Reset state
        at_neg();
        check("rst_req_ready", req_ready, 0);
        check("rst_dp_valid", dp_valid, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_id_error", id_error, 0);
        check("rst_dpr_ready", dpr_ready, 1);
        adv();

        // Round robin, all valid, results returned immediately
        req_tag = {4{4'h1}};
        req_valid = 4'b1111; dp_ready = 1'b1; rsp_ready = 4'b1111; auto_ret = 1'b1;
        for (int c = 0; c < 5; c++) begin
            logic [IW-1:0] g;
            g = IW'(c % N);
            at_neg();
            check("rr_valid", dp_valid, 1);
            check("rr_tag", dp_tag, {g, 4'h1});
            check("rr_ready", req_ready, 4'b0001 << g);
            check("rr_op", dp_op, op_of(int'(g)));
            adv();
        end
        // Async reset mid-burst
        #2;
        rst = 1'b1;
        #1;
        check("arst_dp_valid", dp_valid, 0);
        check("arst_req_ready", req_ready, 0);
        check("arst_rsp_valid", rsp_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_dpr_ready", dpr_ready, 0);
        do_reset();

        // Credit limit on requester 2
        req_tag = {4'h0, 4'h7, 4'h0, 4'h0};
        req_valid = 4'b0100; dp_ready = 1'b1; rsp_ready = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            at_neg();
            check("cr_ready", req_ready, 4'b0100);
            adv();
        end
        at_neg();
        check("cr_full_ready", req_ready, 0);
        check("cr_full_valid", dp_valid, 0);
        check("cr_full_busy", busy, 1);
        adv();
        push_dp(2'd2, 4'h7);
        drive_dp();
        at_neg();
        check("cr_dpr_ready", dpr_ready, 1);
        adv();
        at_neg();
        check("cr_rsp_cycle_ready", req_ready, 0);
        adv();
        at_neg();
        check("cr_fifth_issue", req_ready, 4'b0100);
        adv();
        at_neg();
        check("cr_full_again", req_ready, 0);
        do_reset();

        // Out-of-order return with held response, then back-to-back delivery
        req_tag = {4'hB, 4'hA, 4'h9, 4'h8};
        dp_ready = 1'b1;
        req_valid = 4'b1011; at_neg(); check("ooo_g0", req_ready, 4'b0001); adv();
        req_valid = 4'b1010; at_neg(); check("ooo_g1", req_ready, 4'b0010); adv();
        req_valid = 4'b1000; at_neg(); check("ooo_g3", req_ready, 4'b1000); adv();
        req_valid = '0;
        push_dp(2'd3, 4'hB); push_dp(2'd1, 4'h9); push_dp(2'd0, 4'h8);
        drive_dp();
        at_neg(); check("ooo_dpr_ready0", dpr_ready, 1); adv();
        for (int c = 0; c < 2; c++) begin
            at_neg();
            check("ooo_hold_valid", rsp_valid, 4'b1000);
            check("ooo_hold_dpr_ready", dpr_ready, 0);
            adv();
        end
        rsp_ready = 4'b1111;
        at_neg(); check("ooo_b2b_0", rsp_valid, 4'b1000); check("ooo_b2b_ready", dpr_ready, 1); adv();
        at_neg(); check("ooo_b2b_1", rsp_valid, 4'b0010); adv();
        at_neg(); check("ooo_b2b_2", rsp_valid, 4'b0001); adv();
        at_neg();
        check("ooo_idle_valid", rsp_valid, 0);
        check("ooo_idle_busy", busy, 0);
        check("ooo_sb_empty", rsp_q.size(), 0);
        do_reset();

        // Same-cycle issue and response for requester 1 at cnt=2
        req_tag = {4'h0, 4'h0, 4'h3, 4'h0};
        req_valid = 4'b0010; dp_ready = 1'b1; rsp_ready = 4'b1111;
        for (int c = 0; c < 2; c++) begin
            at_neg(); check("sc_pre_ready", req_ready, 4'b0010); adv();
        end
        req_valid = '0;
        push_dp(2'd1, 4'h3);
        drive_dp();
        at_neg(); adv();
        req_valid = 4'b0010;
        at_neg();
        check("sc_issue", req_ready, 4'b0010);
        check("sc_busy", busy, 1);
        adv();
        for (int c = 0; c < 2; c++) begin
            at_neg(); check("sc_refill", req_ready, 4'b0010); adv();
        end
        at_neg();
        check("sc_limit_ready", req_ready, 0);
        check("sc_limit_valid", dp_valid, 0);
        do_reset();

        // Out-of-range id on a NumReq=5 instance, then the highest legal id
        x_rsp_ready = 5'b11111;
        x_dpr_valid = 1'b1; x_dpr_tag = {3'd6, 4'h2}; x_dpr_res = 38'h1234;
        @(negedge clk);
        check("ide_accept", x_dpr_ready, 1);
        check("ide_pre", x_id_error, 0);
        @(posedge clk); #1;
        x_dpr_valid = 1'b0;
        @(negedge clk);
        check("ide_pulse", x_id_error, 1);
        check("ide_no_rsp", x_rsp_valid, 0);
        check("ide_busy", x_busy, 0);
        @(negedge clk);
        check("ide_pulse_end", x_id_error, 0);
        @(posedge clk); #1;
        x_dpr_valid = 1'b1; x_dpr_tag = {3'd4, 4'h9}; x_dpr_res = 38'h2A_5555_AAAA;
        @(posedge clk); #1;
        x_dpr_valid = 1'b0;
        @(negedge clk);
        check("id4_valid", x_rsp_valid, 5'b10000);
        check("id4_tag", x_rsp_tag, 4'h9);
        check("id4_result", x_rsp_result, 38'h2A_5555_AAAA);
        check("id4_err", x_id_error, 0);
        @(negedge clk);
        check("id4_no_underflow_busy", x_busy, 0);
        do_reset();

        // Flush with three ops outstanding and the response register full
        req_tag = {4'h0, 4'h0, 4'h0, 4'h5};
        req_valid = 4'b0001; dp_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            at_neg(); check("fl_pre_ready", req_ready, 4'b0001); adv();
        end
        req_valid = '0;
        push_dp(2'd0, 4'h5);
        drive_dp();
        at_neg(); adv();
        at_neg(); check("fl_pre_busy", busy, 1); adv();
        flush = 1'b1; req_valid = 4'b1111; rsp_ready = 4'b1111;
        at_neg();
        check("fl_dp_valid", dp_valid, 0);
        check("fl_req_ready", req_ready, 0);
        check("fl_rsp_valid", rsp_valid, 0);
        check("fl_dpr_ready", dpr_ready, 0);
        rsp_q.delete();
        dp_pend.delete();
        adv();
        flush = 1'b0;
        at_neg();
        check("fl_post_busy", busy, 0);
        check("fl_post_rsp", rsp_valid, 0);
        check("fl_post_ptr", req_ready, 4'b0001);
        adv();
        req_valid = '0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
